// File: rtl/csla_bist_pkg.sv
// csla_bist_pkg: FSM states and width helpers for the carry-select adder self-test
package csla_bist_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
  function automatic int idx_w(input int w);
    return 2 * w + 1;
  endfunction
  function automatic int cnt_w(input int w);
    return 2 * w + 2;
  endfunction
endpackage

// File: rtl/csla_golden.sv
// csla_golden: reference a+b+cin producing {cout,s}
module csla_golden #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum
);
  assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/csla_bist.sv
// csla_bist: exhaustive sweep of adder vectors with error count and first-fail capture
module csla_bist
  import csla_bist_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  output logic               dut_cin,
  input  logic [WIDTH-1:0]   dut_s,
  input  logic               dut_cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH+1:0] err_count,
  output logic               fail_valid,
  output logic [2*WIDTH:0]   first_fail
);
  localparam int IW = idx_w(WIDTH);
  localparam int CW = cnt_w(WIDTH);
  localparam int SW = $clog2(SETTLE + 1);
  if (SETTLE < 1) begin : g_bad_settle
    $error("SETTLE must be at least 1");
  end
  state_t        state;
  logic [IW-1:0] idx;
  logic [SW-1:0] settle;
  logic [WIDTH:0] gold;
  logic          miss;
  logic          go;
  logic [CW-1:0] err_next;
  csla_golden #(.WIDTH(WIDTH)) u_golden (
    .a  (dut_a),
    .b  (dut_b),
    .cin(dut_cin),
    .sum(gold)
  );
  assign miss     = {dut_cout, dut_s} != gold;
  assign err_next = err_count + CW'(miss);
  assign go       = start && (state == IDLE || state == DONE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= IDLE;
      idx                       <= '0;
      settle                    <= '0;
      {dut_a, dut_b, dut_cin}   <= '0;
      busy                      <= 1'b0;
      done                      <= 1'b0;
      pass                      <= 1'b0;
      err_count                 <= '0;
      fail_valid                <= 1'b0;
      first_fail                <= '0;
    end else if (go) begin
      state                     <= WAIT;
      idx                       <= '0;
      settle                    <= SW'(SETTLE);
      {dut_a, dut_b, dut_cin}   <= '0;
      busy                      <= 1'b1;
      done                      <= 1'b0;
      pass                      <= 1'b0;
      err_count                 <= '0;
      fail_valid                <= 1'b0;
      first_fail                <= '0;
    end else if (state == WAIT) begin
      settle <= settle - 1'b1;
      if (settle == SW'(1)) state <= CHECK;
    end else if (state == CHECK) begin
      err_count <= err_next;
      if (miss && !fail_valid) begin
        first_fail <= idx;
        fail_valid <= 1'b1;
      end
      if (&idx) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= err_next == '0;
      end else begin
        idx                     <= idx + 1'b1;
        {dut_a, dut_b, dut_cin} <= idx + 1'b1;
        settle                  <= SW'(SETTLE);
        state                   <= WAIT;
      end
    end
  end
endmodule

// File: tb/tb_csla_bist.sv
// tb_csla_bist: randomized fault sweeps scored against a behavioural sweep model
module tb_csla_bist;
  typedef struct {int errs; int ff; bit fv; bit ps; int lat;} exp_t;
  logic clk = 0, rst = 0, start0 = 0, start3 = 0;
  logic [3:0] a0, b0, s0, a3, b3, s3;
  logic cin0, cout0, busy0, done0, pass0, fv0, cin3, cout3, busy3, done3, pass3, fv3;
  logic [9:0] err0, err3;
  logic [8:0] ff0, ff3;
  logic [4:0] raw0, obs0, p1 = 0, p2 = 0, q1 = 0, q2 = 0;
  bit fen = 0, fval = 0, dly0 = 0, pd0 = 0, pd3 = 0;
  int fbit = 0, cyc = 0, t0 = 0, t3 = 0, compared = 0, mism = 0;
  exp_t sq0[$], sq3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  csla_bist dut0 (.clk(clk), .rst(rst), .start(start0), .dut_a(a0), .dut_b(b0), .dut_cin(cin0),
    .dut_s(s0), .dut_cout(cout0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .first_fail(ff0));
  csla_bist #(.SETTLE(3)) dut3 (.clk(clk), .rst(rst), .start(start3), .dut_a(a3), .dut_b(b3), .dut_cin(cin3),
    .dut_s(s3), .dut_cout(cout3), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_valid(fv3), .first_fail(ff3));

  // adder under test for dut0: optional stuck bit, optional two-cycle output lag
  assign raw0 = {1'b0, a0} + {1'b0, b0} + {4'b0, cin0};
  always @(posedge clk) begin
    p1 <= raw0; p2 <= p1;
    q1 <= {1'b0, a3} + {1'b0, b3} + {4'b0, cin3}; q2 <= q1;
  end
  always_comb begin
    obs0 = dly0 ? p2 : raw0;
    if (fen) obs0[fbit] = fval;
  end
  assign {cout0, s0} = obs0;
  assign {cout3, s3} = q2;

  function automatic exp_t sweep(input bit fe, input int fb, input bit fvl, input bit dl, input int settle);
    exp_t e = '{0, 0, 0, 0, 512 * (settle + 1)};
    int prev = 0;
    for (int i = 0; i < 512; i++) begin
      int g = (i >> 5) + ((i >> 1) & 15) + (i & 1);
      int seen = (dl && settle < 2) ? prev : g;
      if (fe) seen = fvl ? (seen | (1 << fb)) : (seen & ~(1 << fb));
      if (seen != g) begin
        if (!e.fv) begin e.ff = i; e.fv = 1; end
        e.errs++;
      end
      prev = g;
    end
    e.ps = e.errs == 0;
    return e;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mism++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic score(input string tag, input exp_t e, input int ec, input int ff, input bit fv, input bit ps, input int lat);
    cmp({tag, ".err_count"}, ec, e.errs);
    cmp({tag, ".first_fail"}, ff, e.ff);
    cmp({tag, ".fail_valid"}, fv, e.fv);
    cmp({tag, ".pass"}, ps, e.ps);
    cmp({tag, ".latency"}, lat, e.lat);
  endtask

  always @(negedge clk) begin
    if (busy0 && done0) cmp("dut0.busy_and_done", 1, 0);
    if (busy3 && done3) cmp("dut3.busy_and_done", 1, 0);
    if (done0 && !pd0) begin
      if (sq0.size() == 0) cmp("dut0.unexpected_done", 1, 0);
      else score("dut0", sq0.pop_front(), err0, ff0, fv0, pass0, cyc - t0);
    end
    if (done3 && !pd3) begin
      if (sq3.size() == 0) cmp("dut3.unexpected_done", 1, 0);
      else score("dut3", sq3.pop_front(), err3, ff3, fv3, pass3, cyc - t3);
    end
    pd0 = done0;
    pd3 = done3;
  end

  task automatic zero_check(input string tag);
    cmp({tag, ".vec0"}, {a0, b0, cin0}, 0);
    cmp({tag, ".flags0"}, {busy0, done0, pass0, fv0}, 0);
    cmp({tag, ".counts0"}, {err0, ff0}, 0);
    cmp({tag, ".all3"}, {a3, b3, cin3, busy3, done3, pass3, fv3, err3, ff3}, 0);
  endtask

  task automatic do_reset(input bit with_start);
    @(negedge clk);
    rst = 1; start0 = with_start; start3 = with_start;
    @(posedge clk); #1;
    zero_check(with_start ? "rst_start" : "rst");
    @(negedge clk);
    rst = 0; start0 = 0; start3 = 0;
    sq0.delete(); sq3.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic run0(input bit fe, input int fb, input bit fvl, input bit dl);
    @(negedge clk);
    fen = fe; fbit = fb; fval = fvl; dly0 = dl;
    sq0.push_back(sweep(fe, fb, fvl, dl, 1));
    start0 = 1;
    @(posedge clk); #1;
    t0 = cyc; start0 = 0;
  endtask

  task automatic wait_done(input bit which, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(which ? done3 : done0) && n < budget);
    if (!(which ? done3 : done0)) cmp(which ? "dut3.done_timeout" : "dut0.done_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    do_reset(0);
    run0(0, 0, 0, 0);
    repeat (300) @(negedge clk);
    start0 = 1;
    @(negedge clk);
    start0 = 0;
    wait_done(0, 3000);
    cmp("done.hold_vec", {a0, b0, cin0}, 9'h1ff);
    run0(1, 4, 0, 0);
    wait_done(0, 3000);
    cmp("cout_stuck0.err", err0, 256);
    cmp("cout_stuck0.first", ff0, 31);
    run0(1, 0, 1, 0);
    wait_done(0, 3000);
    cmp("s0_stuck1.err", err0, 256);
    cmp("s0_stuck1.first", ff0, 0);
    for (int k = 0; k < 4; k++) begin
      run0(1, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 0);
      wait_done(0, 3000);
    end
    run0(0, 0, 0, 0);
    repeat (100) @(negedge clk);
    do_reset(0);
    run0(0, 0, 0, 0);
    repeat ($urandom_range(10, 600)) @(negedge clk);
    start0 = 1;
    @(negedge clk);
    start0 = 0;
    wait_done(0, 3000);
    do_reset(1);
    run0(0, 0, 0, 1);
    wait_done(0, 3000);
    cmp("lag_settle1.err_nonzero", int'(err0 > 0), 1);
    @(negedge clk);
    dly0 = 0;
    sq3.push_back(sweep(0, 0, 0, 1, 3));
    start3 = 1;
    @(posedge clk); #1;
    t3 = cyc; start3 = 0;
    wait_done(1, 5000);
    cmp("lag_settle3.pass", pass3, 1);
    cmp("queues_drained", sq0.size() + sq3.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule

// File: doc/csla_bist.md
# csla_bist

Built-in self-test controller for the 4-bit carry-select adder (`CSLA`); it is the driving and checking end of the adder's `a`/`b`/`cin` → `s`/`cout` interface. On `start` it sweeps every operand/carry combination into the adder and compares each result against an internal golden sum. It counts mismatches and captures the first failing vector, so adder checks run in simulation or on silicon without a testbench loop.

## Interface
- `WIDTH`, 4: adder operand width.
- `SETTLE`, 1: wait cycles between applying a vector and sampling the result; must be ≥1.
- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE.
- `dut_a`  out  WIDTH  operand a to the adder.
- `dut_b`  out  WIDTH  operand b to the adder.
- `dut_cin`  out  1  carry in to the adder.
- `dut_s`  in  WIDTH  adder sum.
- `dut_cout`  in  1  adder carry out.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep finished; held until the next accepted `start` or `rst`.
- `pass`  out  1  valid while `done`; 1 iff `err_count`==0.
- `err_count`  out  2·WIDTH+2  number of mismatching vectors.
- `fail_valid`  out  1  at least one mismatch has been captured.
- `first_fail`  out  2·WIDTH+1  index of the first mismatching vector.

## Operation
- Vector index `idx`, 2·WIDTH+1 bits, with {a,b,cin} = idx. `cin` is the LSB and `a` the MSBs. Order: a outer, b middle, cin inner. N = 2^(2·WIDTH+1), which is 512 at WIDTH=4.
- Golden result: expected {cout,s} = a + b + cin, evaluated at WIDTH+1 bits. Mismatch = any bit of {dut_cout,dut_s} differs.
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE, `start`=1 → WAIT. The same edge does the following:
  - sets idx=0 and drives vector 0;
  - clears `err_count`, `fail_valid` and `first_fail`;
  - loads the settle counter with SETTLE.
- WAIT: decrement the settle counter. When it reaches its final cycle → CHECK.
- CHECK: compare on the edge leaving CHECK.
  - On mismatch: `err_count`+1. If `fail_valid`=0, then `first_fail`=idx and `fail_valid`=1.
  - If idx==N−1 → DONE.
  - Otherwise: idx+1, drive the new vector on the same edge, reload the settle counter, → WAIT.
- DONE, `start`=1 → restart, exactly as from IDLE.
- `start` in WAIT or CHECK is ignored. No abort input exists; only `rst` stops a sweep.
- `busy` = state is WAIT or CHECK. `done` = state is DONE.
- `dut_*` hold their last vector in DONE. They are zero in IDLE.
- `err_count` cannot overflow: its width holds N.

## Timing
- Reset: state=IDLE. All outputs are 0: `dut_a`, `dut_b`, `dut_cin`, `busy`, `done`, `pass`, `err_count`, `fail_valid`, `first_fail`.
- Each vector is held stable for SETTLE+1 cycles. The adder output is sampled SETTLE+1 edges after the vector is applied.
- `start` is accepted at edge 0. `done` rises after edge N·(SETTLE+1): edge 1024 for the defaults, 2048 for SETTLE=3.
- `busy` is high from edge 0 until the edge at which `done` rises. `busy` and `done` are never both high.
- `rst` mid-sweep: at the next edge, everything returns to the reset state. No partial results are retained.
- `rst` and `start` asserted together: `rst` wins.
- `pass` is registered together with `done`, and reflects the final `err_count`.

## Structure
- Package `csla_bist_pkg` holds:
  - the state enum (IDLE/WAIT/CHECK/DONE);
  - the index-width and count-width constants derived from WIDTH.
- One sub-module, `csla_golden`: combinational WIDTH-bit a+b+cin → {cout,s}. It is instantiated once and compared inside CHECK.
- The FSM, the idx counter, the settle counter and the error capture all live in `csla_bist`.

## Test plan
- Fault-free `CSLA`, default parameters, `start` pulsed once:
  - `done` rises after edge 1024;
  - `pass`=1, `err_count`=0, `fail_valid`=0.
- Faulty DUT, `dut_cout` stuck at 0:
  - `err_count`=256, `pass`=0;
  - `first_fail`=31 (a=0, b=15, cin=1).
- Faulty DUT, `dut_s[0]` stuck at 1:
  - `err_count`=256;
  - `first_fail`=0, `fail_valid`=1.
- `start` re-pulsed at cycle 300 mid-sweep:
  - ignored; `done` still at edge 1024, with results identical to a single run;
  - a second `start` in DONE restarts the sweep with cleared counters.
- `rst` at cycle 100 mid-sweep:
  - all outputs 0 at the next edge, state IDLE;
  - a subsequent `start` gives a complete run, `done` 1024 cycles later.
- SETTLE=3 with an adder model whose output is delayed 2 cycles:
  - `pass`=1, `done` after edge 2048;
  - with SETTLE=1 the same model yields `err_count`>0.
